display_ram_arbiter: RTL and testbench
======================================

# display_ram_arbiter

Arbitrates the single write port of the 64x8 display RAM (the buffer read by the LCD12864 driver) among three write requesters, e.g. the stopwatch digit updater, a lap-time writer and a banner/text loader. Requesters present bursts of address/data beats over a valid/ready handshake. The block grants whole bursts in round-robin order and also contains a built-in clear engine that fills the entire RAM with a fill character on request. Its registered outputs drive the RAM `we`, `write_address` and `d` pins directly.

## Interface
- ADDR_WIDTH, 6, RAM address width; the RAM has 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, RAM data width.
- MAX_BURST, 16, maximum accepted beats per grant before forced release (1..255).
- FILL_CHAR, 8'h20, value written by the clear engine (ASCII space).

- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N = 0,1,2) beat valid.
- reqN_addr  in  ADDR_WIDTH  beat address.
- reqN_data  in  DATA_WIDTH  beat data.
- reqN_last  in  1  final beat of burst.
- reqN_ready  out  1  beat accepted this cycle when valid&ready.
- clear_req  in  1  single-cycle pulse; request full-RAM fill.
- clear_busy  out  1  clear pending or in progress.
- clear_done  out  1  one-cycle pulse on final fill write.
- we  out  1  RAM write enable (registered).
- write_address  out  ADDR_WIDTH  RAM write address (registered).
- ram_in  out  DATA_WIDTH  RAM write data (registered).

## Operation
- States: IDLE, GRANT, CLEAR.
- IDLE: if clear is pending -> CLEAR (clear has priority over all requesters). Else if any reqN_valid -> GRANT to the first valid requester searching last_grant+1, +2, +3 (mod 3). Else stay.
- GRANT(g): reqg_ready = 1; all other readys are 0. Each cycle with reqg_valid & reqg_ready accepts one beat and increments beat_cnt. Exit to IDLE after an accepted beat with reqg_last = 1 or beat_cnt reaching MAX_BURST; last_grant <= g. A valid-low cycle is a stall: the grant is held and beat_cnt is unchanged.
- CLEAR: clr_addr runs 0..2^ADDR_WIDTH-1, one write per cycle with data FILL_CHAR. After the top address, clear pending is cleared and the state returns to IDLE.
- clear_req sets a sticky pending flag. A clear_req while pending or in CLEAR is ignored (no second clear). A clear_req arriving during GRANT waits until the burst ends.
- clear_busy = pending | (state == CLEAR).
- Addresses from requesters are passed through unchecked. Out-of-range is impossible by width.

## Timing
- Reset values: state IDLE, last_grant = 2 (so req0 wins first), beat_cnt 0, all reqN_ready 0, we 0, write_address 0, ram_in 0, clear_busy 0, clear_done 0.
- Reset is asynchronous. Assertion mid-burst or mid-clear aborts immediately: no further writes and no clear_done. The pending clear is discarded.
- reqN_ready is decoded from registered state/grant only (no combinational path from any valid).
- Arbitration latency: request valid in IDLE at cycle t -> ready high at t+1.
- Write latency: beat accepted at cycle t -> we = 1 with that addr/data at t+1. we = 0 on every cycle with no accept and no clear write.
- Burst end at cycle t -> IDLE at t+1 -> next grant ready at t+2 (one bubble between bursts).
- Clear: clear_req at t (IDLE) -> clear_busy at t+1, CLEAR at t+1. Writes to addresses 0..63 appear on we at t+2..t+65. clear_done pulses together with the address-63 write. Back in IDLE at t+66.
- Simultaneous clear_req and request valids in IDLE: the clear wins. The requesters are served afterward in round-robin order from the unchanged last_grant.

## Test plan
- req0 3-beat burst (addr 0,1,2; data 8'h30,8'h31,8'h2E; last on beat 3) -> we high 3 consecutive cycles one cycle after each accept; RAM holds "01.".
- All three requesters hold valid with 1-beat bursts continuously -> grant order 0,1,2,0,1,2 with exactly one idle we cycle between grants.
- req1 streams 20 beats with no last, MAX_BURST = 16 -> ready drops after beat 16. req2 (valid) is granted next, then req1 resumes with beat 17.
- Pulse clear_req while req0 is mid-burst -> the burst completes, then 64 writes of 8'h20 to addresses 0..63. clear_done is high exactly on the address-63 write. A second clear_req during the clear is ignored.
- req2 deasserts valid for 5 cycles mid-burst -> grant is held, no writes in the gap, beat_cnt is unchanged, and the burst finishes on last.
- Assert rst low during CLEAR at address 20 -> we = 0 and clear_busy = 0 immediately, no clear_done. After release, req0 is granted first.

Source files
------------

// File: rtl/display_ram_arbiter.sv
// rtl/display_ram_arbiter.sv - round-robin burst arbiter and full-RAM clear engine
// driving the single write port of the LCD display RAM.
module display_ram_arbiter #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    MAX_BURST  = 16,
   parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = 8'h20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  req1_last,
   output logic                  req1_ready,
   input  logic                  req2_valid,
   input  logic [ADDR_WIDTH-1:0] req2_addr,
   input  logic [DATA_WIDTH-1:0] req2_data,
   input  logic                  req2_last,
   output logic                  req2_ready,
   input  logic                  clear_req,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0] ram_in
);

   localparam logic [7:0] MAX_BEATS = 8'(MAX_BURST);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_CLEAR
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [1:0]            last_grant_q, last_grant_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic                  pending_q, pending_d;
   logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;

   logic [2:0]            req_valid;
   logic [1:0]            rr_pick;
   logic                  sel_valid;
   logic                  sel_last;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [7:0]            beat_cnt_inc;

   assign req_valid = {req2_valid, req1_valid, req0_valid};

   // Search order starts one past the most recent owner.
   always_comb begin
      rr_pick = 2'd0;
      case (last_grant_q)
         2'd0:    rr_pick = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
         2'd1:    rr_pick = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
         default: rr_pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      sel_valid = req2_valid;
      sel_last  = req2_last;
      sel_addr  = req2_addr;
      sel_data  = req2_data;
      case (grant_q)
         2'd0: begin
            sel_valid = req0_valid;
            sel_last  = req0_last;
            sel_addr  = req0_addr;
            sel_data  = req0_data;
         end
         2'd1: begin
            sel_valid = req1_valid;
            sel_last  = req1_last;
            sel_addr  = req1_addr;
            sel_data  = req1_data;
         end
         default: ;
      endcase
   end

   assign beat_cnt_inc = beat_cnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      pending_d    = pending_q;
      clr_cnt_d    = clr_cnt_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      done_d       = 1'b0;

      if (clear_req && (state_q != S_CLEAR)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (pending_q || clear_req) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
               pending_d = 1'b1;
            end else if (|req_valid) begin
               state_d    = S_GRANT;
               grant_d    = rr_pick;
               beat_cnt_d = 8'd0;
            end
         end
         S_GRANT: begin
            if (sel_valid) begin
               we_d       = 1'b1;
               addr_d     = sel_addr;
               data_d     = sel_data;
               beat_cnt_d = beat_cnt_inc;
               if (sel_last || (beat_cnt_inc == MAX_BEATS)) begin
                  state_d      = S_IDLE;
                  last_grant_d = grant_q;
               end
            end
         end
         S_CLEAR: begin
            // The counter's top bit marks the cycle after the final fill write.
            if (!clr_cnt_q[ADDR_WIDTH]) begin
               we_d      = 1'b1;
               addr_d    = clr_cnt_q[ADDR_WIDTH-1:0];
               data_d    = FILL_CHAR;
               done_d    = &clr_cnt_q[ADDR_WIDTH-1:0];
               clr_cnt_d = clr_cnt_q + 1'b1;
            end else begin
               state_d   = S_IDLE;
               pending_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         grant_q      <= 2'd0;
         last_grant_q <= 2'd2;
         beat_cnt_q   <= 8'd0;
         pending_q    <= 1'b0;
         clr_cnt_q    <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         pending_q    <= pending_d;
         clr_cnt_q    <= clr_cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         done_q       <= done_d;
      end
   end

   assign req0_ready    = (state_q == S_GRANT) && (grant_q == 2'd0);
   assign req1_ready    = (state_q == S_GRANT) && (grant_q == 2'd1);
   assign req2_ready    = (state_q == S_GRANT) && (grant_q == 2'd2);
   assign clear_busy    = pending_q || (state_q == S_CLEAR);
   assign clear_done    = done_q;
   assign we            = we_q;
   assign write_address = addr_q;
   assign ram_in        = data_q;

endmodule

// File: tb/tb_display_ram_arbiter.sv
// tb/tb_display_ram_arbiter.sv - directed bench with a cycle-level behavioural model
// of the display RAM arbiter and literal checks on the resulting write streams.
module tb_display_ram_arbiter;

   localparam int MAXB = 16;

   typedef struct {
      int         who;
      logic [5:0] addr;
      logic [7:0] data;
      logic       last;
      int         stall;
   } beat_t;

   typedef struct {
      int         cyc;
      logic [5:0] addr;
      logic [7:0] data;
      bit         done;
   } wr_t;

   logic       clk;
   logic       rst;
   logic [2:0] v;
   logic [2:0] l;
   logic [5:0] a [3];
   logic [7:0] d [3];
   logic       clear_req;
   logic       rdy0, rdy1, rdy2;
   logic       clear_busy, clear_done, we;
   logic [5:0] write_address;
   logic [7:0] ram_in;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t bq[$];
   wr_t   wlog[$];
   logic [7:0] dram [64];
   logic [7:0] mram [64];
   bit    acc [3];
   int    cyc;

   int         m_owner;
   int         m_last, m_beats, m_fill;
   bit         m_pend, m_we, m_done;
   logic [5:0] m_addr;
   logic [7:0] m_data;

   display_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req0_addr(a[0]), .req0_data(d[0]), .req0_last(l[0]), .req0_ready(rdy0),
      .req1_valid(v[1]), .req1_addr(a[1]), .req1_data(d[1]), .req1_last(l[1]), .req1_ready(rdy1),
      .req2_valid(v[2]), .req2_addr(a[2]), .req2_data(d[2]), .req2_last(l[2]), .req2_ready(rdy2),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .we(we), .write_address(write_address), .ram_in(ram_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 2; m_beats = 0; m_fill = 0;
      m_pend = 0; m_we = 0; m_done = 0; m_addr = '0; m_data = '0;
   endtask

   // One clock of the arbiter as the rules describe it: owner is -1 (idle),
   // 0..2 (a requester holds the port) or 3 (the clear fill runs).
   task automatic model_step();
      logic [1:0] o;
      int j;
      m_we = 0; m_done = 0;
      if (m_owner == -1) begin
         if (m_pend || clear_req) begin
            m_owner = 3; m_fill = 0; m_pend = 1;
         end else begin
            for (int k = 1; k <= 3; k++) begin
               j = (m_last + k) % 3;
               if (v[j] && m_owner == -1) begin
                  m_owner = j; m_beats = 0;
               end
            end
         end
      end else if (m_owner == 3) begin
         if (m_fill < 64) begin
            m_we = 1; m_addr = 6'(m_fill); m_data = 8'h20;
            m_done = (m_fill == 63);
            m_fill++;
            mram[m_addr] = m_data;
         end else begin
            m_owner = -1; m_pend = 0;
         end
      end else begin
         o = 2'(m_owner);
         if (clear_req) m_pend = 1;
         if (v[o]) begin
            m_we = 1; m_addr = a[o]; m_data = d[o];
            mram[m_addr] = m_data;
            m_beats++;
            if (l[o] || m_beats == MAXB) begin
               m_last = m_owner; m_owner = -1;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("we", int'(we), int'(m_we));
      if (m_we) begin
         chk("write_address", int'(write_address), int'(m_addr));
         chk("ram_in", int'(ram_in), int'(m_data));
      end
      chk("clear_done", int'(clear_done), int'(m_done));
      chk("clear_busy", int'(clear_busy), int'(m_pend || m_owner == 3));
      chk("req0_ready", int'(rdy0), int'(m_owner == 0));
      chk("req1_ready", int'(rdy1), int'(m_owner == 1));
      chk("req2_ready", int'(rdy2), int'(m_owner == 2));
   endtask

   initial begin
      model_reset();
      cyc = 0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else begin
            model_step();
            cyc++;
         end
         #2;
         compare_all();
         if (we === 1'b1) begin
            wlog.push_back('{cyc, write_address, ram_in, clear_done});
            dram[write_address] = ram_in;
         end
      end
   end

   function automatic int first_of(int who);
      int r = -1;
      for (int j = bq.size() - 1; j >= 0; j--) if (bq[j].who == who) r = j;
      return r;
   endfunction

   // Beat sources: drive on the falling edge, note acceptance just before the rising edge.
   initial begin
      int idx;
      v = '0; l = '0;
      for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; acc[i] = 0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            idx = first_of(i);
            if (acc[i] && idx >= 0) begin
               bq.delete(idx);
               idx = first_of(i);
            end
            if (idx < 0) v[i] = 1'b0;
            else if (bq[idx].stall > 0) begin
               v[i] = 1'b0;
               bq[idx].stall = bq[idx].stall - 1;
            end else begin
               v[i] = 1'b1; a[i] = bq[idx].addr; d[i] = bq[idx].data; l[i] = bq[idx].last;
            end
         end
         #4;
         acc[0] = v[0] && rdy0;
         acc[1] = v[1] && rdy1;
         acc[2] = v[2] && rdy2;
      end
   end

   task automatic push(int who, int addr, int data, bit last, int stall);
      bq.push_back('{who, 6'(addr), 8'(data), last, stall});
   endtask

   task automatic wait_quiet(string tag);
      int stable = 0;
      int n = 0;
      while (stable < 3 && n < 600) begin
         @(negedge clk);
         n++;
         if (bq.size() == 0 && m_owner == -1 && !m_pend && !m_we) stable++;
         else stable = 0;
      end
      if (stable < 3) begin
         n_cmp++; n_err++;
         $display("FAIL timeout_%s: got busy after %0d cycles expected quiet", tag, n);
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int bad, n, dn;
      rst = 1'b0; clear_req = 1'b0;
      for (int i = 0; i < 64; i++) begin dram[i] = 8'h00; mram[i] = 8'h00; end
      repeat (3) @(negedge clk);
      chk("reset_we", int'(we), 0);
      chk("reset_busy", int'(clear_busy), 0);
      chk("reset_ready", int'({rdy2, rdy1, rdy0}), 0);
      chk("reset_addr", int'(write_address), 0);
      rst = 1'b1;

      // req0 three-beat burst writes "01."
      wlog.delete();
      push(0, 0, 8'h30, 0, 0); push(0, 1, 8'h31, 0, 0); push(0, 2, 8'h2E, 1, 0);
      wait_quiet("burst3");
      chk("b3_count", wlog.size(), 3);
      chk("b3_ram0", int'(dram[0]), 8'h30);
      chk("b3_ram1", int'(dram[1]), 8'h31);
      chk("b3_ram2", int'(dram[2]), 8'h2E);
      chk("b3_model_ram", int'({mram[0], mram[1], mram[2]}), 24'h30312E);
      if (wlog.size() == 3) chk("b3_back_to_back", wlog[2].cyc - wlog[0].cyc, 2);

      // round robin with all three single-beat requesters
      do_reset();
      wlog.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++) push(i, 10 + i, 8'hA0 + i, 1, 0);
      wait_quiet("rr");
      chk("rr_count", wlog.size(), 6);
      bad = 0;
      for (int k = 0; k < wlog.size(); k++) begin
         if (wlog[k].data != 8'(8'hA0 + (k % 3))) bad++;
         if (k > 0 && wlog[k].cyc - wlog[k-1].cyc != 2) bad++;
      end
      chk("rr_order_gaps_bad", bad, 0);

      // req1 overruns MAX_BURST; req2 slips in, then req1 resumes
      wlog.delete();
      for (int k = 0; k < 20; k++) push(1, k, k, k == 19, 0);
      push(2, 40, 8'hEE, 1, 0);
      wait_quiet("maxburst");
      chk("mb_count", wlog.size(), 21);
      bad = 0;
      for (int k = 0; k < wlog.size(); k++) begin
         n = (k < 16) ? k : ((k == 16) ? 8'hEE : k - 1);
         if (int'(wlog[k].data) != n) bad++;
      end
      chk("mb_sequence_bad", bad, 0);

      // clear requested mid-burst, second request during the fill ignored
      wlog.delete();
      for (int k = 0; k < 4; k++) push(0, k, 8'h50 + k, k == 3, 0);
      n = 0;
      while (!(m_owner == 0 && m_beats >= 1) && n < 100) begin @(negedge clk); n++; end
      chk("clr_burst_started", int'(m_owner == 0 && m_beats >= 1), 1);
      pulse_clear();
      n = 0;
      while (!(m_owner == 3 && m_fill >= 10) && n < 100) begin @(negedge clk); n++; end
      pulse_clear();
      wait_quiet("clear");
      chk("clr_count", wlog.size(), 68);
      bad = 0; dn = 0;
      for (int k = 0; k < wlog.size(); k++) begin
         if (k < 4) begin
            if (wlog[k].data != 8'(8'h50 + k) || wlog[k].done) bad++;
         end else begin
            if (int'(wlog[k].addr) != k - 4 || wlog[k].data != 8'h20) bad++;
            if (wlog[k].done != (k == 67)) bad++;
         end
         if (wlog[k].done) dn++;
      end
      chk("clr_entries_bad", bad, 0);
      chk("clr_done_pulses", dn, 1);
      bad = 0;
      for (int i = 0; i < 64; i++) if (dram[i] != 8'h20) bad++;
      chk("clr_ram_not_space", bad, 0);

      // req2 stalls five cycles before its third beat
      wlog.delete();
      for (int k = 0; k < 4; k++) push(2, 8 + k, 8'h60 + k, k == 3, (k == 2) ? 5 : 0);
      wait_quiet("stall");
      chk("st_count", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("st_gap_12", wlog[1].cyc - wlog[0].cyc, 1);
         chk("st_gap_23", wlog[2].cyc - wlog[1].cyc, 6);
         chk("st_gap_34", wlog[3].cyc - wlog[2].cyc, 1);
         chk("st_data3", int'(wlog[3].data), 8'h63);
      end

      // reset lands while the fill is writing address 20
      wlog.delete();
      pulse_clear();
      n = 0;
      while (!(m_owner == 3 && m_we && m_addr == 6'd20) && n < 100) begin @(negedge clk); n++; end
      rst = 1'b0;
      #1;
      chk("rc_we", int'(we), 0);
      chk("rc_busy", int'(clear_busy), 0);
      chk("rc_done", int'(clear_done), 0);
      chk("rc_writes_before", wlog.size(), 21);
      dn = 0;
      foreach (wlog[k]) if (wlog[k].done) dn++;
      chk("rc_no_done", dn, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wlog.delete();
      push(1, 5, 8'h71, 1, 0);
      push(0, 4, 8'h70, 1, 0);
      wait_quiet("after_reset");
      chk("ar_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("ar_first_req0", int'(wlog[0].data), 8'h70);
         chk("ar_second_req1", int'(wlog[1].data), 8'h71);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200000 ns");
      $fatal(1);
   end

endmodule
